// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - turns a 4-bit random stream into timed, laned spawn events
module spawn_scheduler #(
  parameter int TICK_DIV   = 4,
  parameter int DELAY_BASE = 2,
  parameter int LANES      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] rand_in,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [3:0] spawn_lane,
  output logic [7:0] spawn_count,
  output logic       waiting
);

  // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates cleanly.
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]    BASE_W     = 5'(DELAY_BASE);
  // With 16 lanes the modulo is the identity; the divisor is parked at 1 so it is never 0.
  localparam logic [3:0]    LANES_M    = (LANES >= 16) ? 4'd1 : 4'(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_OFFER = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [4:0]    delay_cnt;
  logic [4:0]    delay_next;
  logic [3:0]    lane_next;
  logic [7:0]    count_next;
  logic [3:0]    lane_pick;
  logic          tick;
  logic          handshake;

  assign tick      = (prescaler == PRESC_LAST);
  assign handshake = spawn_valid & spawn_ready;
  assign lane_pick = (LANES >= 16) ? rand_in : (rand_in % LANES_M);

  // Next-state and next-register values; every target starts from its held value.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    delay_next     = delay_cnt;
    lane_next      = spawn_lane;
    count_next     = spawn_count;
    case (state)
      S_IDLE: begin
        prescaler_next = '0;
        delay_next     = '0;
        if (enable) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // Delay is drawn here; the lane is drawn later on the final tick.
        delay_next     = BASE_W + {1'b0, rand_in};
        prescaler_next = '0;
        state_next     = enable ? S_COUNT : S_IDLE;
      end
      S_COUNT: begin
        if (!enable) begin
          // Abort beats a simultaneous tick: nothing is offered.
          state_next     = S_IDLE;
          prescaler_next = '0;
          delay_next     = '0;
        end else begin
          prescaler_next = tick ? '0 : prescaler + PW'(1);
          if (tick) begin
            if (delay_cnt <= 5'd1) begin
              state_next = S_OFFER;
              lane_next  = lane_pick;
            end else begin
              delay_next = delay_cnt - 5'd1;
            end
          end
        end
      end
      S_OFFER: begin
        // Valid stays up until accepted regardless of enable.
        if (handshake) begin
          if (spawn_count != 8'hFF) begin
            count_next = spawn_count + 8'd1;
          end
          state_next = enable ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; valid/waiting are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      prescaler   <= '0;
      delay_cnt   <= '0;
      spawn_valid <= 1'b0;
      spawn_lane  <= '0;
      spawn_count <= '0;
      waiting     <= 1'b0;
    end else begin
      state       <= state_next;
      prescaler   <= prescaler_next;
      delay_cnt   <= delay_next;
      spawn_valid <= (state_next == S_OFFER);
      spawn_lane  <= lane_next;
      spawn_count <= count_next;
      waiting     <= (state_next == S_COUNT);
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - self-checking bench for spawn_scheduler
module tb_spawn_scheduler;

  localparam int TICK_DIV   = 4;
  localparam int DELAY_BASE = 2;
  localparam int LANES      = 4;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_COUNT = 2;
  localparam int M_OFFER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] rand_in = 4'd0;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [3:0] spawn_lane;
  logic [7:0] spawn_count;
  logic       waiting;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase, remaining COUNT cycles before the offer, lane, count.
  int m_mode  = M_IDLE;
  int m_rem   = 0;
  int m_lane  = 0;
  int m_count = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] rnd;
    logic       rdy;
    logic       exp_valid;
    logic       exp_waiting;
    logic [3:0] exp_lane;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[16];

  spawn_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .DELAY_BASE(DELAY_BASE),
    .LANES     (LANES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rand_in    (rand_in),
    .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid),
    .spawn_lane (spawn_lane),
    .spawn_count(spawn_count),
    .waiting    (waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    if (!reset) begin
      m_mode  = M_IDLE;
      m_rem   = 0;
      m_lane  = 0;
      m_count = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (enable) m_mode = M_LOAD;
        M_LOAD: begin
          d = DELAY_BASE + int'(rand_in);
          if (d < 1) d = 1;
          m_rem  = d * TICK_DIV;
          m_mode = enable ? M_COUNT : M_IDLE;
        end
        M_COUNT: begin
          if (!enable) m_mode = M_IDLE;
          else if (m_rem == 1) begin
            m_lane = int'(rand_in) % LANES;
            m_mode = M_OFFER;
          end else m_rem--;
        end
        default: begin
          if (spawn_ready) begin
            if (m_count < 255) m_count++;
            m_mode = enable ? M_LOAD : M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, int'(spawn_valid), int'(m_mode == M_OFFER));
    chk({tag, "_waiting"}, int'(waiting), int'(m_mode == M_COUNT));
    chk({tag, "_count"}, int'(spawn_count), m_count);
    if (m_mode == M_OFFER) chk({tag, "_lane"}, int'(spawn_lane), m_lane);
  endtask

  initial begin
    int cycles;
    int hs;
    int lane_hold;
    int cnt_hold;

    // rst_n en rnd rdy | valid waiting lane count
    vecs[0]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 4'd2, 8'd0};
    vecs[12] = '{1'b1, 1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 4'd2, 8'd0};
    vecs[13] = '{1'b1, 1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[14] = '{1'b1, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[15] = '{1'b1, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 4'd0, 8'd1};

    #1;
    for (int i = 0; i < 16; i++) begin
      reset       = vecs[i].rst_n;
      enable      = vecs[i].en;
      rand_in     = vecs[i].rnd;
      spawn_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), int'(spawn_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_waiting", i), int'(waiting), int'(vecs[i].exp_waiting));
      chk($sformatf("vec%0d_count", i), int'(spawn_count), int'(vecs[i].exp_count));
      if (vecs[i].exp_valid || !vecs[i].rst_n)
        chk($sformatf("vec%0d_lane", i), int'(spawn_lane), int'(vecs[i].exp_lane));
    end

    // Delay 3+2=5 ticks -> 20 cycles; lane from rand 13 on final tick -> 1.
    enable = 1'b1; spawn_ready = 1'b0; rand_in = 4'd7;
    step(); check_model("t2_load");
    rand_in = 4'd3;
    step(); check_model("t2_count0");
    rand_in = 4'd13;
    cycles = 0;
    while (!spawn_valid && cycles < 100) begin
      step(); check_model("t2_run"); cycles++;
    end
    chk("t2_latency", cycles, 20);
    chk("t2_lane", int'(spawn_lane), 1);

    // Backpressure: offer held stable, count frozen.
    lane_hold = int'(spawn_lane);
    cnt_hold  = int'(spawn_count);
    rand_in   = 4'd2;
    for (int i = 0; i < 10; i++) begin
      rand_in = 4'($urandom_range(0, 15));
      step();
      chk("t3_valid_hold", int'(spawn_valid), 1);
      chk("t3_lane_hold", int'(spawn_lane), lane_hold);
      chk("t3_count_hold", int'(spawn_count), cnt_hold);
    end
    spawn_ready = 1'b1;
    step(); check_model("t3_accept");
    chk("t3_valid_drop", int'(spawn_valid), 0);
    chk("t3_count_inc", int'(spawn_count), cnt_hold + 1);

    // Abort in the 3rd COUNT cycle, then a fresh LOAD with a new delay.
    spawn_ready = 1'b0; rand_in = 4'd5;
    step(); check_model("t4_c1");
    step(); check_model("t4_c2");
    step(); check_model("t4_c3");
    enable = 1'b0;
    step(); check_model("t4_abort");
    chk("t4_waiting", int'(waiting), 0);
    chk("t4_novalid", int'(spawn_valid), 0);
    step(); check_model("t4_idle");
    enable = 1'b1;
    step(); check_model("t4_reload");
    rand_in = 4'd0;
    step(); check_model("t4_count0");
    cycles = 0;
    while (!spawn_valid && cycles < 100) begin
      step(); check_model("t4_run"); cycles++;
    end
    chk("t4_latency", cycles, 8);

    // Reset while offering, then a glitch that misses the edge.
    reset = 1'b0;
    step(); check_model("t6_rst");
    chk("t6_valid", int'(spawn_valid), 0);
    chk("t6_lane", int'(spawn_lane), 0);
    chk("t6_count", int'(spawn_count), 0);
    reset = 1'b1;
    step(); check_model("t6_load");
    step(); check_model("t6_count0");
    cycles = 0;
    while (!spawn_valid && cycles < 100) begin
      step(); check_model("t6_run"); cycles++;
    end
    chk("t6_reoffer", int'(spawn_valid), 1);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    step(); check_model("t6_glitch");
    chk("t6_glitch_valid", int'(spawn_valid), 1);
    spawn_ready = 1'b1;
    step(); check_model("t6_drain");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) != 0);
      enable      = ($urandom_range(0, 15) != 0);
      rand_in     = 4'($urandom_range(0, 15));
      spawn_ready = 1'($urandom_range(0, 1));
      step(); check_model("rnd");
    end

    // Saturation: 260 handshakes from a clean reset.
    reset = 1'b0; enable = 1'b1; spawn_ready = 1'b1; rand_in = 4'd0;
    step(); check_model("t5_rst");
    reset = 1'b1;
    hs = 0; cycles = 0;
    while (hs < 260 && cycles < 20000) begin
      rand_in = 4'($urandom_range(0, 3));
      if (spawn_valid && spawn_ready) hs++;
      step(); check_model("t5_run"); cycles++;
    end
    chk("t5_handshakes", hs, 260);
    chk("t5_count_sat", int'(spawn_count), 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
